// File: rtl/fixed_point_pkg.sv
// Shared fixed-point helpers: width bookkeeping for the adder tree and a
// width-parametrised signed saturation with clamp flag.
package fixed_point_pkg;

    // Widest signed value the saturation helper can handle.
    localparam int unsigned SatMaxW = 128;

    typedef struct packed {
        logic               clamp;
        logic [SatMaxW-1:0] value;
    } sat_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned calc_sw(input int unsigned dw, input int unsigned n);
        return dw + clog2(n);
    endfunction

    function automatic int unsigned calc_acc_w(input int unsigned dw, input int unsigned n,
                                               input int unsigned guard);
        return calc_sw(dw, n) + guard;
    endfunction

    function automatic int unsigned tree_levels(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    // Number of operands left after k pairwise-add levels.
    function automatic int unsigned level_count(input int unsigned n, input int unsigned k);
        int unsigned c;
        c = n;
        for (int unsigned i = 0; i < k; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    function automatic sat_t saturate(input logic signed [SatMaxW-1:0] x, input int unsigned w);
        logic signed [SatMaxW-1:0] max_v;
        logic signed [SatMaxW-1:0] min_v;
        sat_t                      r;
        max_v   = (SatMaxW'(1) <<< (w - 1)) - SatMaxW'(1);
        min_v   = ~max_v;
        r.clamp = 1'b0;
        r.value = x;
        if (x > max_v) begin
            r.value = max_v;
            r.clamp = 1'b1;
        end else if (x < min_v) begin
            r.value = min_v;
            r.clamp = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipelined_fixed_add_tree_stage.sv
// One registered level of the adder tree: adjacent pairs are summed, an odd
// trailing operand is passed through. Operands are already sign-extended.
module add_tree_stage
    import fixed_point_pkg::*;
#(
    parameter int unsigned NIn   = 2,
    parameter int unsigned Width = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic                           valid_i,
    input  logic                           last_i,
    input  logic [NIn*Width-1:0]           data_i,
    output logic                           valid_o,
    output logic                           last_o,
    output logic [((NIn+1)/2)*Width-1:0]   data_o
);
    localparam int unsigned NOut = (NIn + 1) / 2;

    logic [NOut*Width-1:0] data_d;
    logic [NOut*Width-1:0] data_q;
    logic                  valid_q;
    logic                  last_q;

    for (genvar i = 0; i < NOut; i++) begin : g_pair
        if (2 * i + 1 < NIn) begin : g_add
            assign data_d[i*Width +: Width] = data_i[2*i*Width +: Width]
                                            + data_i[(2*i+1)*Width +: Width];
        end else begin : g_pass
            assign data_d[i*Width +: Width] = data_i[2*i*Width +: Width];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            last_q  <= last_i;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipelined_fixed_add_tree.sv
// N-lane signed fixed-point adder: registered pairwise tree, optional packet
// accumulator, saturating output, valid/ready on both sides with global stall.
module pipelined_fixed_add_tree
    import fixed_point_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned FRACT_WIDTH = 8,
    parameter int unsigned N_IN        = 3,
    parameter int unsigned ACCUM       = 0,
    parameter int unsigned ACC_GUARD   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_IN*DATA_WIDTH-1:0] in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_sat,
    output logic                       out_valid,
    input  logic                       out_ready
);
    localparam int unsigned SW    = calc_sw(DATA_WIDTH, N_IN);
    localparam int unsigned ACC_W = calc_acc_w(DATA_WIDTH, N_IN, ACC_GUARD);
    localparam int unsigned LT    = tree_levels(N_IN);

    if (N_IN < 1 || N_IN > 64 || FRACT_WIDTH > DATA_WIDTH || ACC_W >= SatMaxW) begin : g_check
        $error("pipelined_fixed_add_tree: unsupported parameter set");
    end

    logic                    adv;
    logic [N_IN*SW-1:0]      in_ext;
    logic signed [SW-1:0]    tree_sum;
    logic                    tree_valid;
    logic                    tree_last;
    logic signed [ACC_W:0]   acc_total;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic                    sticky_d, sticky_q;
    logic                    out_valid_d, out_valid_q;
    logic                    out_sat_d, out_sat_q;
    logic [DATA_WIDTH-1:0]   out_data_d, out_data_q;
    logic                    is_last;
    sat_t                    acc_sat;
    sat_t                    out_sat_r;
    logic                    unused_sat_hi;

    // Whole pipeline advances together; a held output freezes every stage.
    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    for (genvar i = 0; i < N_IN; i++) begin : g_ext
        assign in_ext[i*SW +: SW] = SW'($signed(in_data[i*DATA_WIDTH +: DATA_WIDTH]));
    end

    for (genvar k = 0; k < LT; k++) begin : g_stage
        localparam int unsigned NIn  = level_count(N_IN, k);
        localparam int unsigned NOut = level_count(N_IN, k + 1);

        logic [NIn*SW-1:0]  d_in;
        logic               v_in;
        logic               l_in;
        logic [NOut*SW-1:0] d_out;
        logic               v_out;
        logic               l_out;

        if (k == 0) begin : g_first
            assign d_in = in_ext;
            assign v_in = in_valid;
            assign l_in = in_last & in_valid;
        end else begin : g_next
            assign d_in = g_stage[k-1].d_out;
            assign v_in = g_stage[k-1].v_out;
            assign l_in = g_stage[k-1].l_out;
        end

        add_tree_stage #(
            .NIn   (NIn),
            .Width (SW)
        ) u_stage (
            .clk_i   (clk),
            .rst_i   (rst),
            .en_i    (adv),
            .valid_i (v_in),
            .last_i  (l_in),
            .data_i  (d_in),
            .valid_o (v_out),
            .last_o  (l_out),
            .data_o  (d_out)
        );
    end

    assign tree_sum   = g_stage[LT-1].d_out;
    assign tree_valid = g_stage[LT-1].v_out;
    assign tree_last  = g_stage[LT-1].l_out;

    // Without accumulation every beat closes its own packet, so acc_q stays zero.
    assign is_last   = (ACCUM == 0) || tree_last;
    assign acc_total = (ACC_W+1)'(tree_sum) + (ACC_W+1)'(acc_q);
    assign acc_sat   = saturate(SatMaxW'(acc_total), ACC_W);
    assign acc_next  = acc_sat.value[ACC_W-1:0];
    assign out_sat_r = saturate(SatMaxW'(acc_next), DATA_WIDTH);

    assign unused_sat_hi = ^{acc_sat.value[SatMaxW-1:ACC_W],
                             out_sat_r.value[SatMaxW-1:DATA_WIDTH]};

    always_comb begin
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (adv) begin
            out_valid_d = 1'b0;
            if (tree_valid) begin
                if (is_last) begin
                    out_valid_d = 1'b1;
                    out_data_d  = out_sat_r.value[DATA_WIDTH-1:0];
                    out_sat_d   = out_sat_r.clamp | acc_sat.clamp | sticky_q;
                    acc_d       = '0;
                    sticky_d    = 1'b0;
                end else begin
                    acc_d    = acc_next;
                    sticky_d = sticky_q | acc_sat.clamp;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_pipelined_fixed_add_tree.sv
// Scoreboard bench: one DUT per accumulate mode, integer reference model,
// decoupled monitors comparing every consumed output.
module tb_pipelined_fixed_add_tree;

    localparam longint AccMax = (longint'(1) <<< 25) - 1;
    localparam longint AccMin = -(longint'(1) <<< 25);

    typedef struct {
        logic [15:0] data;
        logic        sat;
        int          cyc;
        bit          chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [47:0] d0_data = '0;
    logic        d0_valid = 1'b0, d0_last = 1'b0, rdy0 = 1'b1;
    logic        d0_ready, d0_ovalid, d0_osat;
    logic [15:0] d0_odata;

    logic [47:0] d1_data = '0;
    logic        d1_valid = 1'b0, d1_last = 1'b0, rdy1 = 1'b1;
    logic        d1_ready, d1_ovalid, d1_osat;
    logic [15:0] d1_odata;

    exp_t   q0[$];
    exp_t   q1[$];
    longint acc_m    = 0;
    bit     sticky_m = 0;
    bit     rdone;

    pipelined_fixed_add_tree #(
        .DATA_WIDTH (16), .FRACT_WIDTH (8), .N_IN (3), .ACCUM (0), .ACC_GUARD (8)
    ) dut0 (
        .clk (clk), .rst (rst), .in_data (d0_data), .in_valid (d0_valid), .in_last (d0_last),
        .in_ready (d0_ready), .out_data (d0_odata), .out_sat (d0_osat),
        .out_valid (d0_ovalid), .out_ready (rdy0)
    );

    pipelined_fixed_add_tree #(
        .DATA_WIDTH (16), .FRACT_WIDTH (8), .N_IN (3), .ACCUM (1), .ACC_GUARD (8)
    ) dut1 (
        .clk (clk), .rst (rst), .in_data (d1_data), .in_valid (d1_valid), .in_last (d1_last),
        .in_ready (d1_ready), .out_data (d1_odata), .out_sat (d1_osat),
        .out_valid (d1_ovalid), .out_ready (rdy1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint lsum(input logic [47:0] d);
        return longint'($signed(d[15:0])) + longint'($signed(d[31:16]))
             + longint'($signed(d[47:32]));
    endfunction

    function automatic exp_t mk(input longint v, input bit extra);
        exp_t e;
        e.cyc = 0;
        e.chk = 0;
        if (v > 32767) begin
            e.data = 16'h7FFF; e.sat = 1'b1;
        end else if (v < -32768) begin
            e.data = 16'h8000; e.sat = 1'b1;
        end else begin
            e.data = 16'(v); e.sat = 1'b0;
        end
        e.sat = e.sat | extra;
        return e;
    endfunction

    task automatic send0(input logic [47:0] lanes, input bit chk_lat);
        int n;
        n = 0;
        @(negedge clk);
        d0_data = lanes; d0_valid = 1'b1; d0_last = 1'($urandom);
        #1;
        while (!d0_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (!d0_ready) check("send0_accept_timeout", 64'd0, 64'd1);
        else begin
            exp_t e;
            e = mk(lsum(lanes), 1'b0);
            e.cyc = cyc; e.chk = chk_lat;
            q0.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic send1(input logic [47:0] lanes, input bit last);
        int n;
        n = 0;
        @(negedge clk);
        d1_data = lanes; d1_valid = 1'b1; d1_last = last;
        #1;
        while (!d1_ready && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (!d1_ready) check("send1_accept_timeout", 64'd0, 64'd1);
        else begin
            acc_m = acc_m + lsum(lanes);
            if (acc_m > AccMax) begin acc_m = AccMax; sticky_m = 1'b1; end
            else if (acc_m < AccMin) begin acc_m = AccMin; sticky_m = 1'b1; end
            if (last) begin
                q1.push_back(mk(acc_m, sticky_m));
                acc_m = 0; sticky_m = 1'b0;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        d0_valid = 1'b0; d1_valid = 1'b0;
        d0_last = 1'($urandom); d1_last = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 1000) begin
            @(negedge clk); n++;
        end
        check("drain_pending", 64'(q0.size() + q1.size()), 64'd0);
    endtask

    task automatic mon_cycle(input int id, input logic ov, input logic [15:0] od, input logic os,
                             input logic rdy, input logic ir,
                             inout bit hold, inout logic [15:0] hd, inout logic hs);
        exp_t e;
        bit   empty;
        check($sformatf("in_ready%0d", id), 64'(ir), 64'(!ov || rdy));
        if (hold) begin
            check($sformatf("stall_valid%0d", id), 64'(ov), 64'd1);
            check($sformatf("stall_data%0d", id), 64'(od), 64'(hd));
            check($sformatf("stall_sat%0d", id), 64'(os), 64'(hs));
        end
        if (ov && rdy) begin
            empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) check($sformatf("unexpected_out%0d", id), 64'(od), 64'hDEAD_0000);
            else begin
                if (id == 0) e = q0.pop_front();
                else e = q1.pop_front();
                check($sformatf("out_data%0d", id), 64'(od), 64'(e.data));
                check($sformatf("out_sat%0d", id), 64'(os), 64'(e.sat));
                if (e.chk) check("latency", 64'(cyc - e.cyc), 64'd3);
            end
        end
        hold = ov && !rdy;
        hd   = od;
        hs   = os;
    endtask

    initial begin : mon0
        bit          hold;
        logic [15:0] hd;
        logic        hs;
        hold = 0; hd = '0; hs = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (rst) hold = 0;
            else mon_cycle(0, d0_ovalid, d0_odata, d0_osat, rdy0, d0_ready, hold, hd, hs);
        end
    end

    initial begin : mon1
        bit          hold;
        logic [15:0] hd;
        logic        hs;
        hold = 0; hd = '0; hs = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (rst) hold = 0;
            else mon_cycle(1, d1_ovalid, d1_odata, d1_osat, rdy1, d1_ready, hold, hd, hs);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_valid0", 64'(d0_ovalid), 64'd0);
        check("rst_data0", 64'(d0_odata), 64'd0);
        check("rst_sat0", 64'(d0_osat), 64'd0);
        check("rst_ready0", 64'(d0_ready), 64'd1);
        check("rst_valid1", 64'(d1_ovalid), 64'd0);
        check("rst_data1", 64'(d1_odata), 64'd0);
        check("rst_sat1", 64'(d1_osat), 64'd0);
        check("rst_ready1", 64'(d1_ready), 64'd1);

        // Basic sum and latency.
        send0({16'hFF40, 16'h0280, 16'h0100}, 1'b1);
        idle();
        drain();

        // Saturation corners.
        send0({16'h7000, 16'h7000, 16'h7000}, 1'b0);
        send0({16'h9000, 16'h9000, 16'h9000}, 1'b0);
        send0({16'hFFFF, 16'h0001, 16'h7FFF}, 1'b0);
        idle();
        drain();

        // Back-to-back stream with a mid-stream stall.
        fork
            begin
                for (int i = 1; i <= 10; i++) begin
                    send0({16'(-i), 16'(i * 100), 16'(i * 3)}, 1'b0);
                end
                idle();
            end
            begin
                repeat (4) @(negedge clk);
                rdy0 = 1'b0;
                repeat (5) @(negedge clk);
                rdy0 = 1'b1;
            end
        join
        drain();

        // Accumulate: three-beat packet then a single-beat packet.
        send1({16'h0040, 16'h0040, 16'h0080}, 1'b0);
        send1({16'h0040, 16'h0040, 16'h0080}, 1'b0);
        send1({16'h0040, 16'h0040, 16'h0080}, 1'b1);
        send1({16'h0020, 16'h0010, 16'h0010}, 1'b1);
        idle();
        drain();

        // Accumulated overflow, then sticky flag must be gone.
        send1({16'h2000, 16'h2000, 16'h2000}, 1'b0);
        send1({16'h2000, 16'h2000, 16'h2000}, 1'b1);
        send1({16'h0004, 16'h0004, 16'h0008}, 1'b1);
        idle();
        drain();

        // Reset with a partial accumulator and beats in flight.
        for (int i = 0; i < 4; i++) send1({16'h0100, 16'h0200, 16'h0300}, 1'b0);
        @(negedge clk);
        rst = 1'b1; d1_valid = 1'b0; d0_valid = 1'b0;
        acc_m = 0; sticky_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            check("post_rst_valid1", 64'(d1_ovalid), 64'd0);
            check("post_rst_ready1", 64'(d1_ready), 64'd1);
            @(negedge clk);
        end
        send1({16'h0010, 16'h0008, 16'h0008}, 1'b1);
        idle();
        drain();

        // Random beats with random backpressure, plain mode.
        rdone = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send0(48'({$urandom(), $urandom()}), 1'b0);
                    if ($urandom_range(0, 3) == 0) idle();
                end
                idle();
                rdone = 1;
            end
            begin
                while (!rdone) begin
                    @(negedge clk);
                    rdy0 = ($urandom_range(0, 2) != 0);
                end
                rdy0 = 1'b1;
            end
        join
        drain();

        // Random packets with random backpressure, accumulate mode.
        rdone = 0;
        fork
            begin
                for (int p = 0; p < 15; p++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        send1(48'({$urandom(), $urandom()}), b == len - 1);
                        if ($urandom_range(0, 3) == 0) idle();
                    end
                end
                idle();
                rdone = 1;
            end
            begin
                while (!rdone) begin
                    @(negedge clk);
                    rdy1 = ($urandom_range(0, 2) != 0);
                end
                rdy1 = 1'b1;
            end
        join
        drain();

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
